instr_prefetch_queue: RTL
=========================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; legal values 2, 4, 8.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] are 0.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 imem_req_o  output  1  fetch request issued this cycle.
REQ-006 imem_addr_o  output  32  byte address of the request; meaningful only while imem_req_o=1.
REQ-007 imem_valid_i  input  1  fetch response valid; latency 1 or more cycles.
REQ-008 imem_data_i  input  32  instruction word returned with imem_valid_i.
REQ-009 valid_o  output  1  queue head holds an instruction.
REQ-010 ready_i  input  1  decode stage accepts the head this cycle.
REQ-011 instr_o  output  32  head instruction word.
REQ-012 pc_o  output  32  byte address of the head instruction.
REQ-013 redirect_i  input  1  branch taken or jump; flush and refetch.
REQ-014 redirect_pc_i  input  32  new fetch address; bits [1:0] are ignored and treated as 0.

Function
REQ-015 The block SHALL hold a FIFO of DEPTH {pc, instr} entries, with count, fetch_pc, outstanding and drop registers.
REQ-016 At most one request SHALL be in flight, tracked by the outstanding flag.
REQ-017 push SHALL be defined as imem_valid_i & outstanding & ~drop & ~redirect_i.
- pop SHALL be defined as valid_o & ready_i.
- occ_next SHALL be defined as count + push - pop.
REQ-018 imem_req_o SHALL be 1 exactly when ~rst_i, ~redirect_i, (~outstanding | imem_valid_i) and occ_next < DEPTH all hold.
REQ-019 On issue, imem_addr_o SHALL equal fetch_pc, fetch_pc SHALL advance by 4 (32-bit modulo; 0xFFFF_FFFC wraps to 0), and outstanding SHALL be 1 next cycle.
REQ-020 A response with outstanding=1 SHALL clear outstanding unless a new request is issued in the same cycle.
- A response with outstanding=0 SHALL be ignored.
REQ-021 push SHALL write {pc of the matching request, imem_data_i} at the tail; entries SHALL leave in fetch order.
REQ-022 valid_o SHALL equal (count != 0); instr_o and pc_o SHALL come from registered head storage with no combinational path from imem_data_i.
- Latency from response to valid_o is 1 cycle.
REQ-023 pop SHALL remove the head; push and pop in the same cycle SHALL leave count unchanged.
REQ-024 Reservation SHALL guarantee count + outstanding <= DEPTH, so a push never occurs into a full queue.
REQ-025 With redirect_i=1, next cycle the block SHALL have:
- count=0 and valid_o=0;
- fetch_pc = {redirect_pc_i[31:2], 2'b00};
- no request issued in the redirect cycle.
REQ-026 A head popped in the redirect cycle SHALL count as delivered.
REQ-027 If a request is in flight at redirect and no response arrives that cycle, drop SHALL become 1.
- Its later response SHALL be discarded, clearing outstanding and drop.
- The first post-redirect request SHALL issue in that same response cycle.
REQ-028 A response arriving in the redirect cycle SHALL be discarded and SHALL clear outstanding.
REQ-029 The first post-redirect request SHALL issue no earlier than the cycle after redirect_i.
REQ-030 ready_i with valid_o=0 SHALL have no effect.

Reset
REQ-031 While rst_i=1 at a rising edge, the following SHALL become 0:
- count, outstanding, drop;
- all storage, so instr_o=0 and pc_o=0;
- valid_o.
- fetch_pc SHALL become RESET_PC.
REQ-032 imem_req_o SHALL be 0 during any cycle rst_i=1; the first request (addr RESET_PC) SHALL issue the first cycle rst_i=0.
REQ-033 Reset mid-operation SHALL discard queued entries and any in-flight response.
- A response arriving after reset with outstanding=0 SHALL be ignored.

Verification
REQ-034 Reset release, 1-cycle memory, ready_i=1 -> requests 0x0, 0x4, 0x8 on consecutive cycles; valid_o=1 with pc_o=0x0 two cycles after release; one instruction delivered per cycle.
REQ-035 ready_i=0, DEPTH=4 -> exactly 4 requests (0x0..0xC); count=4, imem_req_o stays 0; one pop -> request 0x10 issues in the pop cycle.
REQ-036 3-cycle memory latency, request 0x8 in flight, redirect_i=1 with redirect_pc_i=0x103 -> valid_o=0 next cycle; 0x8 response dropped; next request addr 0x100; first delivered pc_o=0x100.
REQ-037 Response for 0x4 arriving in the same cycle as redirect_i (pc 0x40) -> 0x4 never appears on pc_o; next request 0x40 the following cycle.
REQ-038 fetch_pc=0xFFFF_FFFC -> request 0xFFFF_FFFC, then 0x0000_0000.
REQ-039 rst_i asserted with 3 entries queued and one in flight -> valid_o=0 next cycle; late imem_valid_i ignored; first post-reset pc_o=RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: one fetch in flight, DEPTH-entry {pc, instr} FIFO
// toward decode, with redirect flush and drop of stale in-flight responses.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_mem_r    [DEPTH];
  logic [31:0]      instr_mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] occ_next_s;
  logic [31:0]      fetch_pc_r;
  logic [31:0]      req_pc_r;
  logic             outstanding_r;
  logic             drop_r;
  logic             resp_s;
  logic             push_s;
  logic             pop_s;
  logic             unused_pc_bits_s;

  assign valid_o          = (count_r != {CNT_W{1'b0}});
  assign instr_o          = instr_mem_r[head_r];
  assign pc_o             = pc_mem_r[head_r];
  assign imem_addr_o      = fetch_pc_r;
  assign unused_pc_bits_s = ^redirect_pc_i[1:0];

  // Handshake decode and issue decision; a slot is reserved for every in-flight fetch
  always_comb begin
    resp_s     = imem_valid_i & outstanding_r;
    push_s     = resp_s & ~drop_r & ~redirect_i;
    pop_s      = valid_o & ready_i;
    occ_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    imem_req_o = ~rst_i & ~redirect_i & (~outstanding_r | imem_valid_i)
               & (occ_next_s < CNT_W'(DEPTH));
  end

  // Queue storage, pointers, fetch pc and in-flight tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_mem_r      <= '{default: 32'h0000_0000};
      instr_mem_r   <= '{default: 32'h0000_0000};
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      fetch_pc_r    <= RESET_PC;
      req_pc_r      <= 32'h0000_0000;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
    end else if (redirect_i) begin
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      fetch_pc_r    <= {redirect_pc_i[31:2], 2'b00};
      // a fetch still in flight must have its eventual response thrown away
      outstanding_r <= outstanding_r & ~imem_valid_i;
      drop_r        <= outstanding_r & ~imem_valid_i;
    end else begin
      count_r <= occ_next_s;
      if (push_s) begin
        pc_mem_r[tail_r]    <= req_pc_r;
        instr_mem_r[tail_r] <= imem_data_i;
        tail_r              <= tail_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1'b1);
      end
      if (imem_req_o) begin
        fetch_pc_r    <= fetch_pc_r + 32'd4;
        req_pc_r      <= fetch_pc_r;
        outstanding_r <= 1'b1;
      end else if (resp_s) begin
        outstanding_r <= 1'b0;
      end
      if (resp_s) begin
        drop_r <= 1'b0;
      end
    end
  end

endmodule
